gpio_mmio: RTL and testbench



---
 rtl/gpio_mmio.sv | 156 +++++++++++++++
 tb/tb_gpio_mmio.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped switch/LED peripheral with 2-flop input sync, edge capture and irq.
// Define GPIO_DEBOUNCE_EN to add per-bit debounce counters; otherwise the level follows sync2.
module gpio_mmio #(
    parameter int unsigned SW_W         = 10,
    parameter int unsigned LED_W        = 10,
    parameter logic [15:0] BASE_ADDR    = 16'hC000,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      addr,
    input  logic             we,
    input  logic             re,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             irq
);

    localparam logic [2:0] OFF_LED     = 3'd0;
    localparam logic [2:0] OFF_LED_SET = 3'd1;
    localparam logic [2:0] OFF_LED_CLR = 3'd2;
    localparam logic [2:0] OFF_SW      = 3'd3;
    localparam logic [2:0] OFF_SW_EDGE = 3'd4;
    localparam logic [2:0] OFF_IRQ_EN  = 3'd5;

    if (SW_W == 0 || SW_W > 16) begin : g_bad_sw_w
        $error("gpio_mmio: SW_W must be 1..16");
    end
    if (LED_W == 0 || LED_W > 16) begin : g_bad_led_w
        $error("gpio_mmio: LED_W must be 1..16");
    end
    if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
        $error("gpio_mmio: DEBOUNCE_CYC must be >= 1");
    end

    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  irq_en_q, irq_en_d;
    logic [SW_W-1:0]  sw_edge_q, sw_edge_d;
    logic [SW_W-1:0]  sync1_q, sync1_d;
    logic [SW_W-1:0]  sync2_q, sync2_d;
    logic [SW_W-1:0]  level_prev_q, level_prev_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [SW_W-1:0]  level;
    logic [SW_W-1:0]  edge_clr;
    logic [15:0]      off;
    logic [2:0]       sel;
    logic             in_range;
    logic             unused_wdata;

    // Upper wdata bits are intentionally dropped for narrow registers.
    assign unused_wdata = ^wdata;

    assign off      = addr - BASE_ADDR;
    assign in_range = (off < 16'd6);
    assign sel      = off[2:0];

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned     CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SW_W-1:0]            level_q, level_d;
    logic [SW_W-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // The edge that would take the count to DEBOUNCE_CYC is the one that accepts the new level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(SW_W); i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    // Register writes; SW_EDGE set beats a same-cycle write-1-to-clear.
    always_comb begin
        led_d    = led_q;
        irq_en_d = irq_en_q;
        edge_clr = '0;
        if (we && in_range) begin
            case (sel)
                OFF_LED:     led_d    = wdata[LED_W-1:0];
                OFF_LED_SET: led_d    = led_q | wdata[LED_W-1:0];
                OFF_LED_CLR: led_d    = led_q & ~wdata[LED_W-1:0];
                OFF_SW_EDGE: edge_clr = wdata[SW_W-1:0];
                OFF_IRQ_EN:  irq_en_d = wdata[SW_W-1:0];
                default:     ;
            endcase
        end
        sync1_d      = sw_in;
        sync2_d      = sync1_q;
        level_prev_d = level;
        sw_edge_d    = (sw_edge_q & ~edge_clr) | (level & ~level_prev_q);
    end

    // Reads sample pre-write state and idle at zero so rdata can be OR-combined on the bus.
    always_comb begin
        rdata_d = '0;
        if (re && in_range) begin
            case (sel)
                OFF_LED:     rdata_d[LED_W-1:0] = led_q;
                OFF_SW:      rdata_d[SW_W-1:0]  = level;
                OFF_SW_EDGE: rdata_d[SW_W-1:0]  = sw_edge_q;
                OFF_IRQ_EN:  rdata_d[SW_W-1:0]  = irq_en_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= '0;
            irq_en_q     <= '0;
            sw_edge_q    <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_prev_q <= '0;
            rdata_q      <= '0;
        end else begin
            led_q        <= led_d;
            irq_en_q     <= irq_en_d;
            sw_edge_q    <= sw_edge_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_prev_q <= level_prev_d;
            rdata_q      <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign led_out = led_q;
    assign irq     = |(sw_edge_q & irq_en_q);

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed self-checking bench for gpio_mmio; expected switch latency follows GPIO_DEBOUNCE_EN.
module tb_gpio_mmio;

`ifdef GPIO_DEBOUNCE_EN
    localparam int          LAT         = 5;        // 1 + DEBOUNCE_CYC edges to level
    localparam logic [15:0] GLITCH_EDGE = 16'h0000;
`else
    localparam int          LAT         = 1;
    localparam logic [15:0] GLITCH_EDGE = 16'h0001;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic [9:0]  sw_in = '0;
    logic [9:0]  led_out;
    logic        irq;
    logic [15:0] d;
    int          checks = 0;
    int          errors = 0;

    gpio_mmio #(
        .SW_W        (10),
        .LED_W       (10),
        .BASE_ADDR   (16'hC000),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .we     (we),
        .re     (re),
        .wdata  (wdata),
        .rdata  (rdata),
        .sw_in  (sw_in),
        .led_out(led_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        addr  = a;
        wdata = v;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        @(negedge clk);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re = 1'b0;
        v  = rdata;
    endtask

    initial begin
        // 1. reset state and all-zero reads
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_led", {6'd0, led_out}, 16'h0000);
        chk("reset_irq", {15'd0, irq}, 16'h0000);
        chk("reset_rdata", rdata, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            rd(16'hC000 + 16'(i), d);
            chk($sformatf("reset_read_off%0d", i), d, 16'h0000);
        end

        // 2. LED write / set / clear
        wr(16'hC000, 16'hFFFF);
        chk("led_write", {6'd0, led_out}, 16'h03FF);
        rd(16'hC000, d);
        chk("led_readback", d, 16'h03FF);
        rd(16'hC001, d);
        chk("led_set_reads_zero", d, 16'h0000);
        wr(16'hC002, 16'h0001);
        chk("led_clr", {6'd0, led_out}, 16'h03FE);
        wr(16'hC001, 16'h0001);
        chk("led_set", {6'd0, led_out}, 16'h03FF);

        // 3a. two-cycle glitch on sw_in[0]
        @(negedge clk);
        sw_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        sw_in[0] = 1'b0;
        repeat (10) @(negedge clk);
        rd(16'hC003, d);
        chk("glitch_sw", d, 16'h0000);
        rd(16'hC004, d);
        chk("glitch_edge", d, GLITCH_EDGE);
        wr(16'hC004, 16'hFFFF);
        wr(16'hC005, 16'h0001);

        // 3b. held level: SW read continuously, irq shows the edge bit
        @(negedge clk);
        sw_in[0] = 1'b1;
        addr     = 16'hC003;
        re       = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        chk("sw_before_accept", rdata, 16'h0000);
        chk("edge_before_set", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        chk("sw_accepted", rdata, 16'h0001);
        chk("edge_set", {15'd0, irq}, 16'h0001);
        re = 1'b0;
        rd(16'hC004, d);
        chk("edge_read", d, 16'h0001);

        // 4. interrupt mask and clear
        wr(16'hC004, 16'h0001);
        chk("irq_clear_bit0", {15'd0, irq}, 16'h0000);
        wr(16'hC005, 16'h0002);
        @(negedge clk);
        sw_in[1] = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("irq_rise", {15'd0, irq}, 16'h0001);
        wr(16'hC004, 16'h0002);
        chk("irq_fall", {15'd0, irq}, 16'h0000);
        sw_in[1] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        sw_in[1] = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        addr  = 16'hC004;
        wdata = 16'h0002;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        chk("set_beats_w1c_irq", {15'd0, irq}, 16'h0001);
        rd(16'hC004, d);
        chk("set_beats_w1c_reg", d, 16'h0002);

        // 5. reset in the middle of a sw_in[2] transition
        sw_in = '0;
        repeat (LAT + 3) @(negedge clk);
        sw_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        sw_in[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        rd(16'hC003, d);
        chk("rst_mid_sw", d, 16'h0000);
        rd(16'hC004, d);
        chk("rst_mid_edge", d, 16'h0000);
        rd(16'hC005, d);
        chk("rst_mid_irq_en", d, 16'h0000);
        chk("rst_mid_irq", {15'd0, irq}, 16'h0000);
        chk("rst_mid_led", {6'd0, led_out}, 16'h0000);

        // 6. width truncation, unmapped address, simultaneous read/write
        wr(16'hC005, 16'hFFFF);
        rd(16'hC005, d);
        chk("irq_en_trunc", d, 16'h03FF);
        wr(16'hC005, 16'h0015);
        wr(16'hC000, 16'h0155);
        wr(16'hC007, 16'h1234);
        rd(16'hC007, d);
        chk("unmapped_read", d, 16'h0000);
        rd(16'hC000, d);
        chk("unmapped_led_kept", d, 16'h0155);
        rd(16'hC005, d);
        chk("unmapped_irq_en_kept", d, 16'h0015);
        @(negedge clk);
        addr  = 16'hC000;
        wdata = 16'h0AAA;
        we    = 1'b1;
        re    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        chk("rw_same_pre_value", rdata, 16'h0155);
        chk("rw_same_led", {6'd0, led_out}, 16'h02AA);
        @(negedge clk);
        chk("rdata_idle_zero", rdata, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
